sld_dumper: RTL
===============

// Module: sld_dumper
// PURPOSE
//   Reads a DUMP_SIZE_BYTES region of the SLD memory, starting at byte address 0x0, one 32-bit word at a time.
//   Serialises each word little-endian (byte 0 first) onto the UART TX byte stream through a valid/ready handshake.
//   Host-side read-back path: the host recovers the loaded SLD image to check it, or reads results written by the CPU.
//   The byte order is the same order the host uses to send the image, so the dumped bytes equal the loaded bytes.
// PARAMETERS
//   DUMP_SIZE_BYTES  1300  bytes to dump; multiple of 4 and >= 4 (elaboration-time check, $error otherwise)
//   READ_LATENCY     1     cycles from mem_read_enable to valid mem_read_data; must be >= 1
// PORTS
//   clk             in   1   clock
//   rstn            in   1   synchronous active-low reset
//   start           in   1   single-cycle request to begin a dump; sampled only in S_IDLE / S_DONE
//   mem_read_addr   out  32  byte address of the word being read (multiple of 4)
//   mem_read_enable out  1   read strobe, exactly one cycle per word
//   mem_read_data   in   32  read word, valid READ_LATENCY cycles after the strobe
//   uart_tx_data    out  8   byte to transmit
//   uart_tx_valid   out  1   uart_tx_data is valid
//   uart_tx_ready   in   1   the UART TX accepts the byte this cycle when valid && ready
//   busy            out  1   high while a dump is in progress
//   dump_done       out  1   high while in S_DONE
// BEHAVIOUR
//   - Registers: state, addr counter (32b), word (32b), wait counter (sized to hold READ_LATENCY). Outputs are combinational from state.
//   - Reset: state=S_IDLE, counter=0. All outputs are 0. A reset mid-dump aborts it; uart_tx_valid is low from the cycle after the reset edge.
//   - S_IDLE: start=1 -> counter<=0, go to S_READ_REQ.
//   - S_READ_REQ: mem_read_enable=1, mem_read_addr=counter. Go to S_READ_WAIT and load wait counter = READ_LATENCY.
//   - S_READ_WAIT: decrement the wait counter. When it reaches 1, capture word<=mem_read_data and go to S_SEND_B0.
//     With READ_LATENCY=1, data is captured on the first S_READ_WAIT cycle.
//   - S_SEND_Bn (n=0..3): uart_tx_valid=1, uart_tx_data=word[8n+7:8n].
//     On valid&&ready, advance to S_SEND_B(n+1).
//     Data stays stable while valid && !ready. Valid never drops without a handshake.
//   - S_SEND_B3 handshake: counter<=counter+4.
//     If counter==DUMP_SIZE_BYTES-4 -> S_DONE, else -> S_READ_REQ.
//     The compare uses the pre-increment counter value.
//   - S_DONE: dump_done=1. start=1 -> counter<=0, go to S_READ_REQ (re-dump). Otherwise stay.
//   - busy=1 in every state except S_IDLE and S_DONE.
//   - start while busy: ignored, no effect on the counter or the byte stream.
//   - uart_tx_ready while not sending: ignored.
//   - Only one read is ever outstanding. mem_read_data is ignored outside the capture cycle.
//   - Throughput with ready held high: 4 bytes per (READ_LATENCY+5) cycles.
//   - mem_read_addr = 0 when mem_read_enable = 0.
// TESTING
//   1 DUMP_SIZE_BYTES=8, mem[0]=0x44332211, mem[4]=0x88776655, ready=1, pulse start
//     -> TX bytes 11,22,33,44,55,66,77,88; read addrs 0x0 then 0x4; dump_done=1 after the last byte; exactly 8 handshakes.
//   2 Same memory, ready toggles randomly (about 50%)
//     -> same 8-byte sequence; uart_tx_data stable while valid&&!ready; valid never drops early.
//   3 READ_LATENCY=3, memory model returns data 3 cycles after the strobe
//     -> correct bytes; each strobe is 1 cycle; no new strobe until byte 3 of the previous word is accepted.
//   4 Pulse start again in S_SEND_B1
//     -> ignored; sequence unchanged. Pulse start in S_DONE -> the full 8-byte dump repeats from addr 0x0.
//   5 Assert rstn=0 for 1 cycle during S_SEND_B2 of word 0
//     -> next cycle: valid=0, busy=0, dump_done=0, state S_IDLE. A new start dumps from byte 11 again.
//   6 DUMP_SIZE_BYTES=1300, mem[i]=i, ready=1
//     -> 1300 bytes; last read addr 0x510 (1296); dump_done asserted after byte 1299; no read beyond 0x510.

Source files
------------

// File: rtl/sld_dumper.sv
// Dumps the first DUMP_SIZE_BYTES of SLD memory to the UART TX byte stream, one word per read,
// little-endian (byte 0 first), so the host reads back exactly the byte order it loaded.
module sld_dumper #(
  parameter int DUMP_SIZE_BYTES = 1300,
  parameter int READ_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [31:0] mem_read_addr,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        busy,
  output logic        dump_done,
  output logic [2:0]  dbg_state
);

  localparam int          WAIT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [31:0] LAST_ADDR = 32'(DUMP_SIZE_BYTES - 4);

  if (DUMP_SIZE_BYTES < 4 || (DUMP_SIZE_BYTES % 4) != 0) begin : g_bad_size
    $error("sld_dumper: DUMP_SIZE_BYTES must be a multiple of 4 and >= 4");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("sld_dumper: READ_LATENCY must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_REQ  = 3'd1,
    S_READ_WAIT = 3'd2,
    S_SEND_B0   = 3'd3,
    S_SEND_B1   = 3'd4,
    S_SEND_B2   = 3'd5,
    S_SEND_B3   = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  // TX handshake: a byte transfers on a cycle where uart_tx_valid && uart_tx_ready; once valid
  // rises, valid and data hold until that transfer, and ready is ignored while valid is low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = S_READ_REQ;
        end
      end
      S_READ_REQ: begin
        wait_d  = WAIT_W'(READ_LATENCY);
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        // Count 1 marks the cycle the read data is valid.
        if (wait_q == WAIT_W'(1)) begin
          word_d  = mem_read_data;
          state_d = S_SEND_B0;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_SEND_B0: if (uart_tx_ready) state_d = S_SEND_B1;
      S_SEND_B1: if (uart_tx_ready) state_d = S_SEND_B2;
      S_SEND_B2: if (uart_tx_ready) state_d = S_SEND_B3;
      S_SEND_B3: begin
        if (uart_tx_ready) begin
          cnt_d   = cnt_q + 32'd4;
          state_d = (cnt_q == LAST_ADDR) ? S_DONE : S_READ_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_addr   = '0;
    mem_read_enable = 1'b0;
    uart_tx_data    = '0;
    uart_tx_valid   = 1'b0;
    busy            = 1'b1;
    dump_done       = 1'b0;
    unique case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy      = 1'b0;
        dump_done = 1'b1;
      end
      S_READ_REQ: begin
        mem_read_enable = 1'b1;
        mem_read_addr   = cnt_q;
      end
      S_SEND_B0: begin
        uart_tx_valid = 1'b1;
        uart_tx_data  = word_q[7:0];
      end
      S_SEND_B1: begin
        uart_tx_valid = 1'b1;
        uart_tx_data  = word_q[15:8];
      end
      S_SEND_B2: begin
        uart_tx_valid = 1'b1;
        uart_tx_data  = word_q[23:16];
      end
      S_SEND_B3: begin
        uart_tx_valid = 1'b1;
        uart_tx_data  = word_q[31:24];
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule
